fetch_unit: RTL and testbench

- Instruction-fetch front end. Owns the PC, drives the instruction-memory port, and presents fetched words to the Decode stage through a valid/ready handshake.
- It is the producer end of Decode's Instruction input.
- A 2-entry instruction buffer decouples memory wait states from decode backpressure.
- Branch and jump redirects flush the buffer and restart fetch at the target.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the PC, drives the instruction-memory port and feeds Decode through a
// valid/ready handshake. A 2-entry circular buffer separates memory wait
// states from decode backpressure. A redirect flushes the buffer and restarts
// fetch at the target after a one-cycle bubble.
// Optional feature: define FETCH_PERF_EN to add the Bubble_Cnt output, a
// saturating count of post-boot cycles in which no instruction was offered.

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic [31:0] Instruction,
    output logic [31:0] Inst_PC,
    output logic [31:0] PC_Plus4,
    output logic        Inst_Valid,
    input  logic        Inst_Ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] Bubble_Cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]  DEPTH       = 2'(BUF_DEPTH);
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic        boot_wait_q, boot_wait_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] inst_buf_q [2];
    logic [31:0] inst_buf_d [2];
    logic [31:0] pc_buf_q   [2];
    logic [31:0] pc_buf_d   [2];

    logic        req;
    logic        push;
    logic        pop;
    logic        redirect_taken;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        unused_redirect_lsbs;

    // Low address bits of a redirect target are meaningless for word fetch.
    assign unused_redirect_lsbs = ^Redirect_PC[1:0];
    assign redirect_target      = {Redirect_PC[31:2], 2'b00};

    // Request, handshake and redirect qualification from registered state.
    always_comb begin
        req            = (state_q == S_RUN) && (count_q < DEPTH) && !Redirect;
        inst_valid     = (count_q != 2'd0);
        push           = req && Imem_Ack;
        pop            = inst_valid && Inst_Ready;
        redirect_taken = Redirect && (state_q != S_BOOT);
    end

    // Next-state logic: sequencing FSM, PC and the circular buffer.
    always_comb begin
        state_d     = state_q;
        boot_wait_d = boot_wait_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        inst_buf_d  = inst_buf_q;
        pc_buf_d    = pc_buf_q;

        case (state_q)
            S_BOOT: begin
                // The first edge after reset release only retires the
                // boot wait; fetching starts one full cycle later.
                if (boot_wait_q) begin
                    boot_wait_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (redirect_taken) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = redirect_taken ? S_FLUSH : S_RUN;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (redirect_taken) begin
            pc_d    = redirect_target;
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) begin
                inst_buf_d[tail_q] = Imem_Data;
                pc_buf_d[tail_q]   = pc_q;
                tail_d             = ~tail_q;
                pc_d               = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_BOOT;
            boot_wait_q <= 1'b1;
            pc_q        <= RESET_PC_AL;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            inst_buf_q  <= '{default: 32'h0};
            pc_buf_q    <= '{default: 32'h0};
        end else begin
            state_q     <= state_d;
            boot_wait_q <= boot_wait_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            inst_buf_q  <= inst_buf_d;
            pc_buf_q    <= pc_buf_d;
        end
    end

    assign Imem_Req    = req;
    assign Imem_Addr   = pc_q;
    assign Inst_Valid  = inst_valid;
    assign Instruction = inst_valid ? inst_buf_q[head_q] : 32'h0;
    assign Inst_PC     = inst_valid ? pc_buf_q[head_q] : 32'h0;
    assign PC_Plus4    = Inst_PC + 32'd4;

`ifdef FETCH_PERF_EN
    logic [15:0] bubble_q, bubble_d;

    // Count post-boot cycles with nothing offered to Decode, saturating.
    always_comb begin
        bubble_d = bubble_q;
        if ((state_q == S_RUN || state_q == S_FLUSH) && !inst_valid &&
            (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    // Bubble counter register; only reset clears it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubble_q <= 16'h0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign Bubble_Cnt = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a
// queue-based reference model of the fetch unit. A second instance with a
// reset PC near the top of memory exercises address wrap-around.

module tb_fetch_unit;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        Clk;
    logic        Rst_n;
    logic        ack, rdy, rd;
    logic [31:0] rdpc;

    logic        req, valid;
    logic [31:0] addr, data, inst, ipc, plus4;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_data, w_inst, w_ipc, w_plus4;

`ifdef FETCH_PERF_EN
    logic [15:0] bubble, w_bubble;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    int          m_idle;
    bit          m_booting;
    int          m_bubble;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        rd;
        logic [31:0] rdpc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    assign data   = addr ^ KEY;
    assign w_data = w_addr ^ KEY;

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Imem_Req(req), .Imem_Addr(addr), .Imem_Ack(ack), .Imem_Data(data),
        .Redirect(rd), .Redirect_PC(rdpc),
        .Instruction(inst), .Inst_PC(ipc), .PC_Plus4(plus4),
        .Inst_Valid(valid), .Inst_Ready(rdy)
`ifdef FETCH_PERF_EN
        , .Bubble_Cnt(bubble)
`endif
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .BUF_DEPTH(2)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n),
        .Imem_Req(w_req), .Imem_Addr(w_addr), .Imem_Ack(1'b1), .Imem_Data(w_data),
        .Redirect(1'b0), .Redirect_PC(32'h0),
        .Instruction(w_inst), .Inst_PC(w_ipc), .PC_Plus4(w_plus4),
        .Inst_Valid(w_valid), .Inst_Ready(1'b1)
`ifdef FETCH_PERF_EN
        , .Bubble_Cnt(w_bubble)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic a, input logic r, input logic d,
                           input logic [31:0] dpc, input logic v,
                           input logic [31:0] pc, input logic q,
                           input logic [31:0] ad);
        vec_t t;
        t.ack = a; t.rdy = r; t.rd = d; t.rdpc = dpc;
        t.exp_v = v; t.exp_pc = pc; t.exp_req = q; t.exp_addr = ad;
        vq.push_back(t);
    endtask

    task automatic apply_stimulus(input logic a, input logic r, input logic d,
                                  input logic [31:0] dpc);
        ack = a; rdy = r; rd = d; rdpc = dpc;
    endtask

    // Assert reset, check reset outputs, release at a falling edge.
    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_output("rst_req",   32'(req),   32'h0);
        check_output("rst_addr",  addr,       32'h0);
        check_output("rst_valid", 32'(valid), 32'h0);
        check_output("rst_inst",  inst,       32'h0);
        check_output("rst_ipc",   ipc,        32'h0);
        check_output("rst_plus4", plus4,      32'h4);
        check_output("rst_waddr", w_addr,     WRAP_PC);
`ifdef FETCH_PERF_EN
        check_output("rst_bubble", 32'(bubble), 32'h0);
`endif
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        m_q.delete();
        m_pc      = 32'h0;
        m_idle    = 2;
        m_booting = 1'b1;
        m_bubble  = 0;
    endtask

    function automatic logic model_req(input logic d);
        return (m_idle == 0) && (m_q.size() < 2) && !d;
    endfunction

    // Compare DUT outputs against the model's view of the current cycle.
    task automatic check_model();
        logic er;
        er = model_req(rd);
        check_output("m_req",   32'(req),   32'(er));
        check_output("m_addr",  addr,       m_pc);
        check_output("m_valid", 32'(valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_output("m_ipc",   ipc,   m_q[0]);
            check_output("m_inst",  inst,  m_q[0] ^ KEY);
            check_output("m_plus4", plus4, m_q[0] + 32'd4);
        end else begin
            check_output("m_inst_empty", inst, 32'h0);
        end
`ifdef FETCH_PERF_EN
        check_output("m_bubble", 32'(bubble), 32'(m_bubble));
`endif
    endtask

    // Advance the model across one rising edge.
    task automatic model_step();
        logic er, p;
        er = model_req(rd);
        p  = (m_q.size() != 0) && rdy;
        if (!m_booting && m_q.size() == 0 && m_bubble < 65535) m_bubble++;
        if (rd && !m_booting) begin
            m_q.delete();
            m_pc   = {rdpc[31:2], 2'b00};
            m_idle = 1;
        end else begin
            if (p) void'(m_q.pop_front());
            if (er && ack) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (m_idle > 0) begin
                m_idle--;
                if (m_idle == 0) m_booting = 1'b0;
            end
        end
    endtask

    initial begin
        Rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // ack rdy rd rdpc | valid inst_pc req addr
        add_vec(1,1,0,32'h00, 0,32'h00,0,32'h00);
        add_vec(1,1,0,32'h00, 0,32'h00,0,32'h00);
        add_vec(1,1,0,32'h00, 0,32'h00,1,32'h00);
        add_vec(1,1,0,32'h00, 1,32'h00,1,32'h04);
        add_vec(1,1,0,32'h00, 1,32'h04,1,32'h08);
        add_vec(1,1,0,32'h00, 1,32'h08,1,32'h0C);
        add_vec(1,1,0,32'h00, 1,32'h0C,1,32'h10);
        add_vec(1,0,0,32'h00, 1,32'h10,1,32'h14);
        add_vec(1,0,0,32'h00, 1,32'h10,0,32'h18);
        add_vec(1,0,0,32'h00, 1,32'h10,0,32'h18);
        add_vec(1,1,0,32'h00, 1,32'h10,0,32'h18);
        add_vec(1,1,0,32'h00, 1,32'h14,1,32'h18);
        add_vec(0,1,0,32'h00, 1,32'h18,1,32'h1C);
        add_vec(0,1,0,32'h00, 0,32'h00,1,32'h1C);
        add_vec(0,1,0,32'h00, 0,32'h00,1,32'h1C);
        add_vec(1,1,0,32'h00, 0,32'h00,1,32'h1C);
        add_vec(1,1,0,32'h00, 1,32'h1C,1,32'h20);
        add_vec(1,0,0,32'h00, 1,32'h20,1,32'h24);
        add_vec(1,0,1,32'h40, 1,32'h20,0,32'h28);
        add_vec(1,1,0,32'h00, 0,32'h00,0,32'h40);
        add_vec(1,1,0,32'h00, 0,32'h00,1,32'h40);
        add_vec(1,1,0,32'h00, 1,32'h40,1,32'h44);
        add_vec(1,1,1,32'h43, 1,32'h44,0,32'h48);
        add_vec(1,1,0,32'h00, 0,32'h00,0,32'h40);
        add_vec(1,1,0,32'h00, 0,32'h00,1,32'h40);
        add_vec(1,1,0,32'h00, 1,32'h40,1,32'h44);

        $display("[TB] directed vectors");
        do_reset();
        for (int k = 0; k < vq.size(); k++) begin
            apply_stimulus(vq[k].ack, vq[k].rdy, vq[k].rd, vq[k].rdpc);
            #1;
            check_output($sformatf("v%0d_valid", k), 32'(valid), 32'(vq[k].exp_v));
            check_output($sformatf("v%0d_req", k),   32'(req),   32'(vq[k].exp_req));
            check_output($sformatf("v%0d_addr", k),  addr,       vq[k].exp_addr);
            if (vq[k].exp_v) begin
                check_output($sformatf("v%0d_ipc", k),   ipc,   vq[k].exp_pc);
                check_output($sformatf("v%0d_inst", k),  inst,  vq[k].exp_pc ^ KEY);
                check_output($sformatf("v%0d_plus4", k), plus4, vq[k].exp_pc + 32'd4);
            end else begin
                check_output($sformatf("v%0d_inst0", k), inst, 32'h0);
            end
            // Wrap instance streams from FFFF_FFF8 with zero-wait memory.
            if (k >= 3 && k <= 5) begin
                logic [31:0] wpc;
                wpc = WRAP_PC + 32'(4 * (k - 3));
                check_output($sformatf("wrap%0d_valid", k), 32'(w_valid), 32'h1);
                check_output($sformatf("wrap%0d_ipc", k),   w_ipc,   wpc);
                check_output($sformatf("wrap%0d_plus4", k), w_plus4, wpc + 32'd4);
                check_output($sformatf("wrap%0d_inst", k),  w_inst,  wpc ^ KEY);
            end
            @(posedge Clk);
            @(negedge Clk);
        end

        $display("[TB] randomized run against reference model");
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                logic [31:0] t;
                t = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
                apply_stimulus($urandom_range(0, 3) != 0,
                               $urandom_range(0, 3) != 0,
                               $urandom_range(0, 15) == 0, t);
                #1;
                check_model();
                @(posedge Clk);
                model_step();
                @(negedge Clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
